alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares the single combinational ALU between two requesters: slot 0 is the execute stage, slot 1 is the branch/compare unit.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- The block arbitrates round-robin, latches operator and operands, sequences one ALU evaluation and holds a registered result until the owner accepts it.
- It sits between the decode/issue logic and the existing ALU instance.

Parameters:
- NUM_REQ, 2, number of requesters. Fixed at 2 in this revision; other values are illegal.
- DATA_W, 32, operand and result width. Must equal the ALU width.

Ports:
- clk  input  1  single clock.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  [1:0]  request valid, one bit per requester.
- req_ready  output  [1:0]  request accepted this cycle, one bit per requester.
- req_operator  input  [7:0]  two 4-bit ALU operator codes; requester i occupies [4i+3:4i].
- req_operand1  input  [63:0]  two 32-bit first operands; requester i occupies [32i+31:32i].
- req_operand2  input  [63:0]  two 32-bit second operands, same packing.
- rsp_valid  output  [1:0]  result valid for requester i.
- rsp_ready  input  [1:0]  requester i accepts its result.
- rsp_result  output  32  registered result, shared bus; meaningful only where rsp_valid is set.
- rsp_is_zero  output  1  registered zero flag, using the ALU_RESULT_IS_ZERO / ALU_RESULT_IS_NOT_ZERO encoding.
- illegal_op  output  1  one-cycle pulse when an accepted operator is not one of the nine defined codes.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE, last_grant=1 (so requester 0 wins first).
  - req_ready=0, rsp_valid=0, rsp_result=0, rsp_is_zero=ALU_RESULT_IS_ZERO, illegal_op=0.
  - An operation in flight is dropped; no response is ever issued for it.
- FSM states IDLE, EXEC, RESP:
  - IDLE: grant = round-robin pick among req_valid, preferring the requester that is not last_grant. req_ready[grant]=1 combinationally; the other bit is 0. On a handshake, latch the operator, both operands and the owner id; set last_grant=id; go to EXEC. With no valid request, stay in IDLE.
  - EXEC: the ALU is driven from the latched registers. On the clock edge, capture result and zero flag into the output registers and go to RESP. If the operator is not one of ADD/SUB/XOR/OR/SLL/SRL/SRA/SLT/SLTU: capture result=0 and is_zero=ALU_RESULT_IS_ZERO, and pulse illegal_op for one cycle.
  - RESP: rsp_valid[owner]=1 and rsp_result is held stable. req_ready=0. On rsp_ready[owner], go to IDLE. rsp_ready on the non-owner bit is ignored.
- Latency and throughput: request handshake at edge k gives rsp_valid high from cycle k+2. Best-case throughput is one operation per 3 cycles.
- Request rules: a requester must not drop req_valid or change its payload before req_ready. The arbiter does not check this.
- Simultaneous valids: grants alternate strictly, with no starvation. A lone requester is granted on every IDLE visit.
- Shift amount: the full 32-bit operand2 is passed to the ALU unmodified; no masking to 5 bits.

Optional Feature:
- Macro: ALU_ARB_BYPASS_EN.
- Defined: the EXEC state is removed. The ALU is driven combinationally from the granted request's payload, and the result is registered at the request handshake edge k. rsp_valid is high from k+1, throughput is one operation per 2 cycles, and illegal_op pulses in cycle k+1.
- Undefined: behaviour is as described above.

Decomposition:
- Shared package holds:
  - ALU operator code constants and the ALU_RESULT_IS_ZERO / ALU_RESULT_IS_NOT_ZERO constants, reused as-is.
  - An FSM state enum: IDLE=2'd0, EXEC=2'd1, RESP=2'd2.
  - A function that checks whether an operator code is legal.
- One sub-module is natural: alu_rr_picker, a combinational 2-way round-robin grant taking (valid[1:0], last_grant) and returning (grant_valid, grant_id).
- The existing ALU is instantiated once inside the block.

Test Plan:
- Single ADD: r0 sends 5+7, rsp_ready=1 → rsp_valid[0] at k+2, rsp_result=12, rsp_is_zero=NOT_ZERO, back in IDLE at k+3.
- Contention: both requesters continuously valid, r0 SUB 9−4, r1 SLT −1<1 → grant order r0, r1, r0, r1. Results 5 to r0 and 1 to r1, never swapped.
- Backpressure: hold rsp_ready[1]=0 for 4 cycles after an r1 SRA of 0x80000000 by 4 → rsp_result stays 0xF8000000 and req_ready=00 throughout; both stay stable until release.
- Zero flag and illegal op:
  - SUB 3−3 → result 0, rsp_is_zero=ALU_RESULT_IS_ZERO.
  - Operator 4'hF → result 0 and a single-cycle illegal_op pulse.
- Reset mid-operation: assert rst during EXEC → outputs reset immediately (asynchronously), no rsp_valid is ever issued for that request, and the first grant after reset goes to r0.
- Bypass build with ALU_ARB_BYPASS_EN: r0 OR 0x0F|0xF0 → rsp_result=0xFF at k+1; back-to-back requests are accepted every 2 cycles.

Source files
------------

// File: rtl/alu_share_arbiter_pkg.sv
// Shared constants, FSM state type and operator-legality helper for the
// two-requester ALU share arbiter.
package alu_share_arbiter_pkg;

    localparam int ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'h0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'h1;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'h2;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'h3;
    localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'h4;
    localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'h5;
    localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'h6;
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'h7;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'h8;

    localparam logic ALU_RESULT_IS_ZERO     = 1'b1;
    localparam logic ALU_RESULT_IS_NOT_ZERO = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    function automatic logic alu_op_legal(input logic [ALU_OP_W-1:0] op);
        case (op)
            ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_SLL,
            ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU shared by the execute stage and the branch/compare unit.
// Shift amounts use the full operand2 value, so amounts >= DATA_W saturate.
module alu
    import alu_share_arbiter_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [ALU_OP_W-1:0] op,
    input  logic [DATA_W-1:0]   operand1,
    input  logic [DATA_W-1:0]   operand2,
    output logic [DATA_W-1:0]   result,
    output logic                result_is_zero
);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = operand1 + operand2;
            ALU_SUB:  result = operand1 - operand2;
            ALU_XOR:  result = operand1 ^ operand2;
            ALU_OR:   result = operand1 | operand2;
            ALU_SLL:  result = operand1 << operand2;
            ALU_SRL:  result = operand1 >> operand2;
            ALU_SRA:  result = $signed(operand1) >>> operand2;
            ALU_SLT:  result = {{(DATA_W-1){1'b0}}, $signed(operand1) < $signed(operand2)};
            ALU_SLTU: result = {{(DATA_W-1){1'b0}}, operand1 < operand2};
            default:  result = '0;
        endcase
        result_is_zero = (result == '0) ? ALU_RESULT_IS_ZERO : ALU_RESULT_IS_NOT_ZERO;
    end

endmodule

// File: rtl/alu_rr_picker.sv
// Two-way round-robin grant: prefers the requester that did not win last time.
module alu_rr_picker (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_id
);

    logic prefer;

    always_comb begin
        prefer      = ~last_grant;
        grant_valid = |valid;
        grant_id    = valid[prefer] ? prefer : last_grant;
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one ALU between two valid/ready requesters.
// Define ALU_ARB_BYPASS_EN to drop the EXEC state and evaluate at the grant edge.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ALU_OP_W-1:0]   req_operator,
    input  logic [NUM_REQ*DATA_W-1:0]     req_operand1,
    input  logic [NUM_REQ*DATA_W-1:0]     req_operand2,
    output logic [NUM_REQ-1:0]            rsp_valid,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [DATA_W-1:0]             rsp_result,
    output logic                          rsp_is_zero,
    output logic                          illegal_op
);

    arb_state_e          state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                owner_q, owner_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                is_zero_q, is_zero_d;
    logic                illegal_q, illegal_d;

    logic                grant_valid, grant_id;
    logic [ALU_OP_W-1:0] gnt_op;
    logic [DATA_W-1:0]   gnt_a, gnt_b;
    logic [ALU_OP_W-1:0] alu_op;
    logic [DATA_W-1:0]   alu_a, alu_b, alu_result;
    logic                alu_is_zero;
    logic [DATA_W-1:0]   cap_result;
    logic                cap_is_zero, cap_illegal;

    alu_rr_picker u_picker (
        .valid       (req_valid),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign gnt_op = grant_id ? req_operator[2*ALU_OP_W-1:ALU_OP_W] : req_operator[ALU_OP_W-1:0];
    assign gnt_a  = grant_id ? req_operand1[2*DATA_W-1:DATA_W]     : req_operand1[DATA_W-1:0];
    assign gnt_b  = grant_id ? req_operand2[2*DATA_W-1:DATA_W]     : req_operand2[DATA_W-1:0];

`ifdef ALU_ARB_BYPASS_EN
    assign alu_op = gnt_op;
    assign alu_a  = gnt_a;
    assign alu_b  = gnt_b;
`else
    logic [ALU_OP_W-1:0] op_q, op_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;

    assign alu_op = op_q;
    assign alu_a  = a_q;
    assign alu_b  = b_q;
`endif

    alu #(.DATA_W(DATA_W)) u_alu (
        .op             (alu_op),
        .operand1       (alu_a),
        .operand2       (alu_b),
        .result         (alu_result),
        .result_is_zero (alu_is_zero)
    );

    // Undefined operators are squashed to a zero result rather than trusting the ALU default.
    always_comb begin
        cap_illegal = !alu_op_legal(alu_op);
        cap_result  = cap_illegal ? '0 : alu_result;
        cap_is_zero = cap_illegal ? ALU_RESULT_IS_ZERO : alu_is_zero;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        result_d     = result_q;
        is_zero_d    = is_zero_q;
        illegal_d    = 1'b0;
        req_ready    = '0;
        rsp_valid    = '0;
`ifndef ALU_ARB_BYPASS_EN
        op_d = op_q;
        a_d  = a_q;
        b_d  = b_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    req_ready[grant_id] = 1'b1;
                    owner_d             = grant_id;
                    last_grant_d        = grant_id;
`ifdef ALU_ARB_BYPASS_EN
                    result_d  = cap_result;
                    is_zero_d = cap_is_zero;
                    illegal_d = cap_illegal;
                    state_d   = RESP;
`else
                    op_d    = gnt_op;
                    a_d     = gnt_a;
                    b_d     = gnt_b;
                    state_d = EXEC;
`endif
                end
            end
`ifndef ALU_ARB_BYPASS_EN
            EXEC: begin
                result_d  = cap_result;
                is_zero_d = cap_is_zero;
                illegal_d = cap_illegal;
                state_d   = RESP;
            end
`endif
            RESP: begin
                rsp_valid[owner_q] = 1'b1;
                if (rsp_ready[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            result_q     <= '0;
            is_zero_q    <= ALU_RESULT_IS_ZERO;
            illegal_q    <= 1'b0;
`ifndef ALU_ARB_BYPASS_EN
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            result_q     <= result_d;
            is_zero_q    <= is_zero_d;
            illegal_q    <= illegal_d;
`ifndef ALU_ARB_BYPASS_EN
            op_q <= op_d;
            a_q  <= a_d;
            b_q  <= b_d;
`endif
        end
    end

    assign rsp_result  = result_q;
    assign rsp_is_zero = is_zero_q;
    assign illegal_op  = illegal_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed-vector bench for alu_share_arbiter; expected values are hand-computed.
`timescale 1ns/1ps
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [7:0]  req_operator = '0;
    logic [63:0] req_operand1 = '0;
    logic [63:0] req_operand2 = '0;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = '0;
    logic [31:0] rsp_result;
    logic        rsp_is_zero;
    logic        illegal_op;

    int n_checks = 0;
    int n_pass   = 0;

    alu_share_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_operator (req_operator),
        .req_operand1 (req_operand1),
        .req_operand2 (req_operand2),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_is_zero  (rsp_is_zero),
        .illegal_op   (illegal_op)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %s: 0x%08h", tag, got);
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_payload(input int id, input logic [3:0] op,
                               input logic [31:0] a, input logic [31:0] b);
        if (id == 0) begin
            req_operator[3:0]  = op;
            req_operand1[31:0] = a;
            req_operand2[31:0] = b;
        end else begin
            req_operator[7:4]   = op;
            req_operand1[63:32] = a;
            req_operand2[63:32] = b;
        end
    endtask

    // Issue one lone request from a negedge, check latency, result, flags and release.
    task automatic run_op(input string tag, input int id, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_ill, input int hold);
        int n;
        logic [1:0] own;
        logic exp_zero;
        own      = (id == 0) ? 2'b01 : 2'b10;
        exp_zero = (exp_res == 32'd0) ? ALU_RESULT_IS_ZERO : ALU_RESULT_IS_NOT_ZERO;
        set_payload(id, op, a, b);
        req_valid[id] = 1'b1;
        #1;
        n = 0;
        while (req_ready !== own && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check({tag, " req_ready"}, {30'd0, req_ready}, {30'd0, own});
        @(posedge clk);
        @(negedge clk);
        req_valid[id] = 1'b0;
`ifndef ALU_ARB_BYPASS_EN
        #1;
        check({tag, " exec rsp_valid"}, {30'd0, rsp_valid}, 32'd0);
        @(negedge clk);
`endif
        #1;
        check({tag, " rsp_valid"}, {30'd0, rsp_valid}, {30'd0, own});
        check({tag, " result"}, rsp_result, exp_res);
        check({tag, " is_zero"}, {31'd0, rsp_is_zero}, {31'd0, exp_zero});
        check({tag, " illegal_op"}, {31'd0, illegal_op}, {31'd0, exp_ill});
        if (hold > 0) begin
            // other requester pushes and offers rsp_ready: both must be ignored
            req_valid[1-id] = 1'b1;
            rsp_ready[1-id] = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk); #1;
                check({tag, " hold rsp_valid"}, {30'd0, rsp_valid}, {30'd0, own});
                check({tag, " hold result"}, rsp_result, exp_res);
                check({tag, " hold req_ready"}, {30'd0, req_ready}, 32'd0);
            end
        end
        rsp_ready[id] = 1'b1;
        @(negedge clk);
        req_valid = '0;
        rsp_ready = '0;
        #1;
        check({tag, " released rsp_valid"}, {30'd0, rsp_valid}, 32'd0);
        check({tag, " illegal_op low"}, {31'd0, illegal_op}, 32'd0);
        // back in IDLE: a fresh lone request is offered ready at once (withdrawn before the edge)
        req_valid[id] = 1'b1;
        #1;
        check({tag, " idle again"}, {30'd0, req_ready}, {30'd0, own});
        req_valid = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int grants[4];
        int n_grant;
        int n_rsp;
        int n;

        repeat (2) @(negedge clk);
        #1;
        check("reset rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("reset rsp_result", rsp_result, 32'd0);
        check("reset rsp_is_zero", {31'd0, rsp_is_zero}, {31'd0, ALU_RESULT_IS_ZERO});
        check("reset illegal_op", {31'd0, illegal_op}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset req_ready", {30'd0, req_ready}, 32'd0);

        run_op("add r0", 0, ALU_ADD, 32'd5, 32'd7, 32'd12, 1'b0, 0);
        run_op("sra r1 backpressure", 1, ALU_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 4);

        // contention: r1 was last granted, so r0 must win first, then strict alternation
        @(negedge clk);
        set_payload(0, ALU_SUB, 32'd9, 32'd4);
        set_payload(1, ALU_SLT, 32'hFFFF_FFFF, 32'd1);
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        n_grant = 0;
        n_rsp   = 0;
        for (int c = 0; c < 24; c++) begin
            if (n_grant >= 4) req_valid = '0;
            #1;
            if (req_ready != 2'b00 && n_grant < 4) begin
                grants[n_grant] = req_ready[1] ? 1 : 0;
                n_grant++;
            end
            if (rsp_valid != 2'b00) begin
                check("contention rsp owner", {30'd0, rsp_valid}, (n_rsp % 2 == 0) ? 32'd1 : 32'd2);
                check("contention result", rsp_result, rsp_valid[1] ? 32'd1 : 32'd5);
                n_rsp++;
            end
            @(negedge clk);
        end
        rsp_ready = '0;
        check("contention grant count", n_grant, 32'd4);
        check("contention rsp count", n_rsp, 32'd4);
        for (int g = 0; g < 4; g++) begin
            if (g < n_grant) check($sformatf("contention grant %0d", g), grants[g], g % 2);
        end

        run_op("sub zero", 0, ALU_SUB, 32'd3, 32'd3, 32'd0, 1'b0, 0);
        run_op("illegal op", 1, 4'hF, 32'd123, 32'd456, 32'd0, 1'b1, 0);
        run_op("sltu", 0, ALU_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd1, 1'b0, 0);
        run_op("sll wide shift", 1, ALU_SLL, 32'h0000_00FF, 32'd40, 32'd0, 1'b0, 0);
        run_op("xor", 0, ALU_XOR, 32'hF0F0_0000, 32'h0FF0_0001, 32'hFF00_0001, 1'b0, 0);
        run_op("or", 0, ALU_OR, 32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, 1'b0, 0);

        // reset with r0 in flight (last grant r0, so without reset r1 would win next)
        @(negedge clk);
        set_payload(0, ALU_ADD, 32'd1, 32'd2);
        req_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        #2;
        rst = 1'b1;
        #1;
        check("midreset rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("midreset rsp_result", rsp_result, 32'd0);
        check("midreset rsp_is_zero", {31'd0, rsp_is_zero}, {31'd0, ALU_RESULT_IS_ZERO});
        check("midreset illegal_op", {31'd0, illegal_op}, 32'd0);
        @(negedge clk); #1;
        check("midreset held rsp_valid", {30'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        set_payload(0, ALU_ADD, 32'd20, 32'd22);
        set_payload(1, ALU_ADD, 32'd100, 32'd1);
        req_valid = 2'b11;
        #1;
        check("postreset first grant", {30'd0, req_ready}, 32'd1);
        check("postreset no stale rsp", {30'd0, rsp_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        rsp_ready = 2'b01;
        #1;
        n = 0;
        while (rsp_valid == 2'b00 && n < 10) begin
            @(negedge clk); #1; n++;
        end
        check("postreset rsp_valid", {30'd0, rsp_valid}, 32'd1);
        check("postreset result", rsp_result, 32'd42);
        @(negedge clk);
        rsp_ready = '0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
